// File: rtl/mips_mem_responder.sv
// Unified instruction/data word store for the single-cycle MIPS core, with error and access tracking.
// Latency: fetch and load data are registered and appear one cycle after the enabling edge.
// Backpressure: none; every enabled access completes in one cycle, and bad stores are dropped.
module mips_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_ram_ena,
    input  logic [31:0]      pc,
    output logic [31:0]      instr,
    input  logic             data_ram_ena,
    input  logic             data_ram_wea,
    input  logic [31:0]      alu_out,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    output logic             err_misalign,
    output logic             err_range,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage is deliberately not reset so that contents survive a core reset.
    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] pc_idx;
    logic [ADDR_W-1:0] d_idx;
    logic              pc_in_rng;
    logic              d_in_rng;
    logic              pc_mis;
    logic              d_mis;
    logic              ld;
    logic              st_ok;
    logic              fetch_err;
    logic              data_err;
    logic              mis_hit;
    logic              rng_hit;

    assign pc_idx    = pc[ADDR_W+1:2];
    assign d_idx     = alu_out[ADDR_W+1:2];
    assign pc_in_rng = (pc[31:ADDR_W+2] == '0);
    assign d_in_rng  = (alu_out[31:ADDR_W+2] == '0);
    assign pc_mis    = (pc[1:0] != 2'b00);
    assign d_mis     = (alu_out[1:0] != 2'b00);

    assign ld        = data_ram_ena & ~data_ram_wea;
    // Only aligned, in-range stores reach the array.
    assign st_ok     = data_ram_ena & data_ram_wea & d_in_rng & ~d_mis;

    assign fetch_err = inst_ram_ena & (~pc_in_rng | pc_mis);
    assign data_err  = data_ram_ena & (~d_in_rng | d_mis);

    // Out-of-range takes precedence, so misalignment only counts for in-range addresses.
    assign rng_hit   = (inst_ram_ena & ~pc_in_rng) | (data_ram_ena & ~d_in_rng);
    assign mis_hit   = (inst_ram_ena & pc_in_rng & pc_mis) | (data_ram_ena & d_in_rng & d_mis);

    // Array write; an edge seen while reset is low must not disturb contents.
    always_ff @(posedge clk) begin
        if (rst && st_ok) begin
            mem[d_idx] <= write_data;
        end
    end

    // Instruction fetch with write-first forwarding from a same-cycle store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr <= '0;
        end else if (inst_ram_ena) begin
            if (!pc_in_rng) begin
                instr <= '0;
            end else if (st_ok && (d_idx == pc_idx)) begin
                instr <= write_data;
            end else begin
                instr <= mem[pc_idx];
            end
        end
    end

    // Data load path and saturating load/store counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            if (ld) begin
                read_data <= d_in_rng ? mem[d_idx] : 32'h0;
                if (rd_cnt != '1) begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
            end
            if (st_ok && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky error flags; the address latches only for the first error, preferring the data side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
            err_addr     <= '0;
        end else begin
            if (mis_hit) begin
                err_misalign <= 1'b1;
            end
            if (rng_hit) begin
                err_range <= 1'b1;
            end
            if (!err_misalign && !err_range && (fetch_err || data_err)) begin
                err_addr <= data_err ? alu_out : pc;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed checks of the memory responder: readback, collisions, error tracking, hold, saturation.
// Latency: samples outputs on the falling edge after each driven rising edge.
// Backpressure: not applicable; the responder never stalls.
module tb_mips_mem_responder;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst;
    logic             inst_ram_ena;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             data_ram_ena;
    logic             data_ram_wea;
    logic [31:0]      alu_out;
    logic [31:0]      write_data;
    logic [31:0]      read_data;
    logic             err_misalign;
    logic             err_range;
    logic [31:0]      err_addr;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    int errors = 0;
    int checks = 0;

    mips_mem_responder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_ram_ena (inst_ram_ena),
        .pc           (pc),
        .instr        (instr),
        .data_ram_ena (data_ram_ena),
        .data_ram_wea (data_ram_wea),
        .alu_out      (alu_out),
        .write_data   (write_data),
        .read_data    (read_data),
        .err_misalign (err_misalign),
        .err_range    (err_range),
        .err_addr     (err_addr),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_instr"},     instr, 32'h0);
        check({tag, "_read_data"}, read_data, 32'h0);
        check({tag, "_err_mis"},   {31'h0, err_misalign}, 32'h0);
        check({tag, "_err_rng"},   {31'h0, err_range}, 32'h0);
        check({tag, "_err_addr"},  err_addr, 32'h0);
        check({tag, "_rd_cnt"},    {28'h0, rd_cnt}, 32'h0);
        check({tag, "_wr_cnt"},    {28'h0, wr_cnt}, 32'h0);
    endtask

    // One clock of stimulus starting and ending on a falling edge; enables drop afterwards.
    task automatic cyc(input logic ie, input logic [31:0] p, input logic de, input logic we,
                       input logic [31:0] a, input logic [31:0] wd);
        inst_ram_ena = ie;
        pc           = p;
        data_ram_ena = de;
        data_ram_wea = we;
        alu_out      = a;
        write_data   = wd;
        @(negedge clk);
        inst_ram_ena = 1'b0;
        data_ram_ena = 1'b0;
        data_ram_wea = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        rst          = 1'b0;
        inst_ram_ena = 1'b0;
        pc           = 32'h0;
        data_ram_ena = 1'b0;
        data_ram_wea = 1'b0;
        alu_out      = 32'h0;
        write_data   = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b1;
        @(negedge clk);

        // Store then load back
        st(32'h10, 32'hDEADBEEF);
        ld(32'h10);
        check("readback", read_data, 32'hDEADBEEF);
        check("readback_wr_cnt", {28'h0, wr_cnt}, 32'd1);
        check("readback_rd_cnt", {28'h0, rd_cnt}, 32'd1);

        // Fetch and store to the same word in one cycle: write-first
        cyc(1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'h12345678);
        check("collide_instr", instr, 32'h12345678);
        ld(32'h20);
        check("collide_load", read_data, 32'h12345678);

        // Misaligned store is dropped, flagged, and read_data holds
        st(32'h13, 32'hAAAA5555);
        check("mis_st_wr_cnt", {28'h0, wr_cnt}, 32'd2);
        check("mis_st_flag", {31'h0, err_misalign}, 32'd1);
        check("mis_st_rng", {31'h0, err_range}, 32'd0);
        check("mis_st_addr", err_addr, 32'h13);
        check("mis_st_hold", read_data, 32'h12345678);
        ld(32'h10);
        check("mis_st_word4", read_data, 32'hDEADBEEF);
        check("mis_st_rd_cnt", {28'h0, rd_cnt}, 32'd3);

        // Asynchronous reset pulse between edges
        #1 rst = 1'b0;
        #1 check_cleared("pulse1");
        #1 rst = 1'b1;
        @(negedge clk);

        // Out of range load, then a misaligned load keeps the first error address
        st(32'h4, 32'h0BADF00D);
        check("post_rst_wr_cnt", {28'h0, wr_cnt}, 32'd1);
        ld(32'h1000);
        check("oor_data", read_data, 32'h0);
        check("oor_rng", {31'h0, err_range}, 32'd1);
        check("oor_mis", {31'h0, err_misalign}, 32'd0);
        check("oor_addr", err_addr, 32'h1000);
        ld(32'h5);
        check("mis_ld_data", read_data, 32'h0BADF00D);
        check("mis_ld_flag", {31'h0, err_misalign}, 32'd1);
        check("mis_ld_addr", err_addr, 32'h1000);

        // Out-of-range fetch returns zero; in-range fetch sees contents kept across reset
        cyc(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0);
        check("oor_fetch", instr, 32'h0);
        cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        check("fetch_kept", instr, 32'hDEADBEEF);

        // Enables low with write enable high: nothing changes
        pc           = 32'h20;
        alu_out      = 32'h10;
        write_data   = 32'h11111111;
        data_ram_wea = 1'b1;
        repeat (5) @(negedge clk);
        data_ram_wea = 1'b0;
        check("hold_instr", instr, 32'hDEADBEEF);
        check("hold_read", read_data, 32'h0BADF00D);
        check("hold_wr_cnt", {28'h0, wr_cnt}, 32'd1);
        ld(32'h10);
        check("hold_nowrite", read_data, 32'hDEADBEEF);

        // Load counter saturates
        for (int i = 0; i < 20; i++) ld(32'h10);
        check("sat_rd_cnt", {28'h0, rd_cnt}, 32'd15);

        // Asynchronous reset clears outputs without any clock edge
        #1 rst = 1'b0;
        #1 check_cleared("pulse2");
        #1 rst = 1'b1;
        @(negedge clk);
        ld(32'h20);
        check("survive_rst", read_data, 32'h12345678);

        // A store whose edge coincides with reset low is suppressed
        rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h99999999);
        rst = 1'b1;
        @(negedge clk);
        ld(32'h10);
        check("rst_edge_nowrite", read_data, 32'hDEADBEEF);
        check("rst_edge_wr_cnt", {28'h0, wr_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the single-cycle MIPS core's instruction and data RAM interfaces.
- Serves instruction fetches on the PC port and loads/stores on the AluOut/WriteData port from one unified word-addressed store.
- Models block-RAM timing: reads are registered with exactly 1-cycle latency.
- Detects misaligned and out-of-range accesses; keeps sticky error status and access counters for the bench.

Parameters:
- ADDR_W, 10, word-address bits; store depth is 2**ADDR_W 32-bit words.
- CNT_W, 16, width of the saturating access counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- inst_ram_ena  input  1  fetch enable.
- pc  input  32  fetch byte address.
- instr  output  32  fetched word, registered.
- data_ram_ena  input  1  data access enable.
- data_ram_wea  input  1  1 = store, 0 = load; only meaningful when data_ram_ena = 1.
- alu_out  input  32  data byte address.
- write_data  input  32  store data.
- read_data  output  32  load data, registered.
- err_misalign  output  1  sticky flag: an access with addr[1:0] != 0 occurred.
- err_range  output  1  sticky flag: an access hit address bits above ADDR_W+1 that are nonzero.
- err_addr  output  32  byte address of the first error since reset.
- rd_cnt  output  CNT_W  saturating count of accepted data loads.
- wr_cnt  output  CNT_W  saturating count of accepted data stores.

Behaviour:
- Reset (rst = 0, asynchronous):
  - instr, read_data, err_*, err_addr, rd_cnt and wr_cnt clear to 0 immediately.
  - The store array is not reset; contents are preserved across reset.
- Word index = addr[ADDR_W+1:2]. An address is in range iff addr[31:ADDR_W+2] == 0.
- Fetch:
  - If inst_ram_ena = 1 at edge N, instr after edge N = mem[pc index].
  - If inst_ram_ena = 0, instr holds its value.
- Load (data_ram_ena = 1, data_ram_wea = 0):
  - read_data after the edge = mem[alu_out index]; rd_cnt increments.
  - read_data holds whenever there is no load.
- Store (data_ram_ena = 1, data_ram_wea = 1):
  - mem[index] <= write_data at the edge; wr_cnt increments.
  - read_data holds.
- data_ram_wea = 1 with data_ram_ena = 0: no write, no count.
- Misaligned access (addr[1:0] != 0):
  - Load returns the word at the aligned index and counts normally.
  - Store is dropped and not counted.
  - err_misalign sets; a misaligned fetch also sets it.
- Out-of-range access:
  - Load or fetch returns 0.
  - Store is dropped.
  - err_range sets.
  - Out-of-range wins over misaligned: only err_range sets.
- err_addr:
  - Captured only when no error flag is yet set.
  - If a fetch error and a data error occur in the same cycle, the data address is captured.
- Collisions:
  - Fetch and store to the same word in the same cycle: write-first; instr returns write_data.
  - Load after a store to the same word on the next cycle returns the new data.
- Counters saturate at 2**CNT_W-1 and never wrap.
- Reset asserted mid-access: an edge coincident with rst = 0 performs no write.
- All outputs are registers; no combinational path from inputs to outputs.

Test Plan:
- Reset/readback: apply rst = 0 → all outputs 0. Release, store 0xDEADBEEF at 0x10, then load 0x10 → read_data = 0xDEADBEEF one cycle after the load edge; wr_cnt = 1, rd_cnt = 1.
- Fetch/store collision: pc = 0x20 with a store of 0x12345678 to 0x20 in the same cycle → instr = 0x12345678 after that edge. Next load of 0x20 → 0x12345678.
- Misaligned store: store 0xAAAA5555 to 0x13 → memory word 4 unchanged, wr_cnt unchanged, err_misalign = 1, err_addr = 0x13.
- Out of range, then misaligned: load 0x0000_1000 (ADDR_W = 10) → read_data = 0, err_range = 1, err_addr = 0x1000. A later misaligned load at 0x5 → err_misalign = 1, err_addr stays 0x1000.
- Enables/hold: inst_ram_ena = 0 and data_ram_ena = 0 with data_ram_wea = 1 for 5 cycles → instr and read_data hold, no write, counters unchanged.
- Saturation and async reset: CNT_W = 4, 20 consecutive loads → rd_cnt = 15. Pulse rst low between edges → outputs clear without a clock edge; a stored word written before the reset still reads back its value after it.
